interlock_timer: RTL
====================

INTERLOCK_TIMER -- requirements
Module: interlock_timer

Interface
REQ-001 Parameter CLK_HZ, default 50000000, clk cycles per one-second tick (prescaler divisor DIV).
REQ-002 Parameter WAIT_S, default 300, seconds of the occupancy wait (5 min).
REQ-003 Parameter EVAC_S, default 8, seconds of the evacuate interval.
REQ-004 Parameter PRESS_S, default 7, seconds of the pressurize interval.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 waiting  input  1  level request for the wait interval, from the interlock controller.
REQ-008 evacuating  input  1  level request for the evacuate interval.
REQ-009 pressurizing  input  1  level request for the pressurize interval.
REQ-010 waitFinished  output  1  level, wait interval expired.
REQ-011 evacuateFinished  output  1  level, evacuate interval expired.
REQ-012 pressurizeFinished  output  1  level, pressurize interval expired.
REQ-013 busy  output  1  high in RUN and DONE.
REQ-014 remaining  output  9  seconds left in the active interval, unsigned binary.
REQ-015 conflict  output  1  one-cycle pulse: more than one request high in IDLE.

Function
REQ-016 FSM states shall be IDLE, RUN, DONE; a 2-bit channel register (WAIT/EVAC/PRESS) shall record the accepted request.
REQ-017 In IDLE with any request high, the next edge shall go to RUN, latch the channel, load remaining with the channel's seconds, and clear the prescaler.
REQ-018 Simultaneous requests in IDLE: priority waiting > evacuating > pressurizing; conflict pulses high for that one edge.
REQ-019 In RUN, the prescaler shall count 0..DIV-1 and wrap; a tick occurs on the cycle it equals DIV-1.
REQ-020 On each tick, remaining shall decrement by 1; on the tick where remaining==1, the next state is DONE and remaining becomes 0.
REQ-021 Latency: the finished output shall rise exactly N*DIV edges after the accept edge, where N is the channel's seconds.
REQ-022 Only the finished output of the latched channel shall assert; it stays high in DONE while the latched request stays high.
REQ-023 In DONE, deassertion of the latched request shall return the FSM to IDLE on the next edge, with finished low.
REQ-024 In RUN, deassertion of the latched request shall abort: next edge IDLE, remaining=0, no finished output.
REQ-025 In RUN and DONE, requests on non-latched channels shall be ignored and shall not raise conflict.
REQ-026 After returning to IDLE, a still-high request shall be accepted on the following edge, so a minimum of one IDLE cycle separates intervals.
REQ-027 A parameter value of 0 shall be treated as 1; values above 511 are illegal.

Reset
REQ-028 When reset is high at an edge: state IDLE, prescaler 0, remaining 0, and all finished outputs, busy and conflict 0.
REQ-029 Reset mid-interval shall discard the count; no finished output shall assert in the cycle after reset.

Configuration
REQ-030 Macro INTERLOCK_TIMER_FASTSIM_EN: when defined, DIV shall be 1 (one tick every clk); when undefined, DIV shall equal CLK_HZ.

Verification (INTERLOCK_TIMER_FASTSIM_EN defined, default seconds)
REQ-031 evacuating held high from accept edge E0 -> evacuateFinished rises at E0+8, remaining reads 8,7,...,1,0, busy is high from E0 onward.
REQ-032 waiting and pressurizing both rise in the same IDLE cycle -> wait channel latched, conflict=1 for one cycle, waitFinished at E0+300, pressurizeFinished stays 0.
REQ-033 pressurizing dropped at E0+3 -> FSM returns to IDLE, remaining=0, and pressurizeFinished never asserts.
REQ-034 reset pulsed at E0+5 of an evacuate interval -> all outputs are 0; with evacuating still high, it is re-accepted after reset and finishes 8 edges later.
REQ-035 evacuateFinished high, then evacuating dropped and pressurizing raised in the same cycle -> one IDLE cycle, then accept; pressurizeFinished rises 7 edges after that accept.

Source files
------------

// File: rtl/interlock_timer_if.sv
// Request/status bundle between the interlock controller (master) and interlock_timer (slave).
interface interlock_timer_if;
  logic       waiting;
  logic       evacuating;
  logic       pressurizing;
  logic       waitFinished;
  logic       evacuateFinished;
  logic       pressurizeFinished;
  logic       busy;
  logic [8:0] remaining;
  logic       conflict;

  modport master (
    output waiting, evacuating, pressurizing,
    input  waitFinished, evacuateFinished, pressurizeFinished, busy, remaining, conflict
  );

  modport slave (
    input  waiting, evacuating, pressurizing,
    output waitFinished, evacuateFinished, pressurizeFinished, busy, remaining, conflict
  );
endinterface

// File: rtl/interlock_timer.sv
// Seconds-resolution interval timer for the wait/evacuate/pressurize phases of an interlock.
// Define INTERLOCK_TIMER_FASTSIM_EN to tick once per clk instead of once per CLK_HZ clks.
module interlock_timer #(
  parameter int CLK_HZ  = 50000000,
  parameter int WAIT_S  = 300,
  parameter int EVAC_S  = 8,
  parameter int PRESS_S = 7
) (
  input  logic               clk,
  input  logic               reset,
  interlock_timer_if.slave   bus
);
`ifdef INTERLOCK_TIMER_FASTSIM_EN
  localparam int DIV = 1;
`else
  localparam int DIV = (CLK_HZ < 1) ? 1 : CLK_HZ;
`endif
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  // A zero-second interval still has to pass through RUN, so it runs for one second.
  localparam logic [8:0] WAIT_N  = (WAIT_S  == 0) ? 9'd1 : 9'(WAIT_S);
  localparam logic [8:0] EVAC_N  = (EVAC_S  == 0) ? 9'd1 : 9'(EVAC_S);
  localparam logic [8:0] PRESS_N = (PRESS_S == 0) ? 9'd1 : 9'(PRESS_S);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {CH_WAIT, CH_EVAC, CH_PRESS} chan_e;

  state_e          state_q, state_d;
  chan_e           chan_q, chan_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [8:0]      rem_q, rem_d;
  logic            conflict_q, conflict_d;
  logic [2:0]      req;
  logic            req_lat;
  logic            tick;

  assign req  = {bus.pressurizing, bus.evacuating, bus.waiting};
  assign tick = (presc_q == PW'(DIV - 1));

  always_comb begin
    req_lat = 1'b0;
    case (chan_q)
      CH_WAIT:  req_lat = req[0];
      CH_EVAC:  req_lat = req[1];
      CH_PRESS: req_lat = req[2];
      default:  req_lat = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      chan_q     <= CH_WAIT;
      presc_q    <= '0;
      rem_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      presc_q    <= presc_d;
      rem_q      <= rem_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    presc_d    = presc_q;
    rem_d      = rem_q;
    conflict_d = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        rem_d   = '0;
        if (|req) begin
          state_d    = RUN;
          conflict_d = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);
          if (req[0]) begin
            chan_d = CH_WAIT;
            rem_d  = WAIT_N;
          end else if (req[1]) begin
            chan_d = CH_EVAC;
            rem_d  = EVAC_N;
          end else begin
            chan_d = CH_PRESS;
            rem_d  = PRESS_N;
          end
        end
      end
      RUN: begin
        // Abort takes precedence over a coincident tick.
        if (!req_lat) begin
          state_d = IDLE;
          presc_d = '0;
          rem_d   = '0;
        end else if (tick) begin
          presc_d = '0;
          if (rem_q == 9'd1) begin
            state_d = DONE;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - 9'd1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      DONE: begin
        if (!req_lat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy               = (state_q != IDLE);
  assign bus.waitFinished       = (state_q == DONE) && (chan_q == CH_WAIT);
  assign bus.evacuateFinished   = (state_q == DONE) && (chan_q == CH_EVAC);
  assign bus.pressurizeFinished = (state_q == DONE) && (chan_q == CH_PRESS);
  assign bus.remaining          = rem_q;
  assign bus.conflict           = conflict_q;
endmodule
